mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 133 +++++++++++++
 tb/tb_mult_div_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: 32-bit iterative signed/unsigned multiply-divide unit with HI/LO registers
// Ports: clk, rst_n (async, active-low); start/op/a/b launch an operation from IDLE;
//   hi_we/lo_we/wdata write HI/LO while idle; busy/done/div_by_zero report status;
//   hi/lo are the architectural result registers.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic is_div_q, is_div_d;
  logic [31:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] rem_q, rem_d;
  logic neg_q, neg_d, neg_rem_q, neg_rem_d, b_zero_q, b_zero_d;
  logic done_q, done_d, dz_q, dz_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic is_signed;
  logic [31:0] mag_a_in, mag_b_in;
  logic [32:0] add_sum, shifted, trial;
  logic [63:0] prod;
  logic [31:0] quot, rmd;
  assign is_signed = ~op[0];
  assign mag_a_in = (is_signed && a[31]) ? -a : a;
  assign mag_b_in = (is_signed && b[31]) ? -b : b;
  // Multiply: acc high half accumulates, low half holds the multiplier shifting out
  assign add_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a_q} : 33'd0);
  // Divide: acc low half shifts dividend bits out of the top and quotient bits in at the bottom
  assign shifted = {rem_q, acc_q[31]};
  assign trial = shifted - {1'b0, mag_b_q};
  assign prod = neg_q ? -acc_q : acc_q;
  // A zero divisor yields an all-ones quotient regardless of sign; the remainder is the dividend
  assign quot = b_zero_q ? 32'hFFFF_FFFF : neg_q ? -acc_q[31:0] : acc_q[31:0];
  assign rmd = neg_rem_q ? -rem_q : rem_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    is_div_d = is_div_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    acc_d = acc_q;
    rem_d = rem_q;
    neg_d = neg_q;
    neg_rem_d = neg_rem_q;
    b_zero_d = b_zero_q;
    done_d = 1'b0;
    dz_d = 1'b0;
    hi_d = hi_q;
    lo_d = lo_q;
    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d = CALC;
          cnt_d = 5'd0;
          is_div_d = op[1];
          mag_a_d = mag_a_in;
          mag_b_d = mag_b_in;
          neg_d = is_signed && (a[31] ^ b[31]);
          neg_rem_d = is_signed && a[31];
          b_zero_d = b == 32'd0;
          acc_d = {32'd0, op[1] ? mag_a_in : mag_b_in};
          rem_d = 32'd0;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 5'd1;
        state_d = (cnt_q == 5'd31) ? FINISH : CALC;
        acc_d = is_div_q ? {32'd0, acc_q[30:0], ~trial[32]} : {add_sum, acc_q[31:1]};
        rem_d = (is_div_q && !trial[32]) ? trial[31:0] : is_div_q ? shifted[31:0] : rem_q;
      end
      FINISH: begin
        state_d = IDLE;
        done_d = 1'b1;
        dz_d = is_div_q && b_zero_q;
        {hi_d, lo_d} = is_div_q ? {rmd, quot} : prod;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= 5'd0;
      is_div_q <= 1'b0;
      mag_a_q <= 32'd0;
      mag_b_q <= 32'd0;
      acc_q <= 64'd0;
      rem_q <= 32'd0;
      neg_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q <= 1'b0;
      done_q <= 1'b0;
      dz_q <= 1'b0;
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      is_div_q <= is_div_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      acc_q <= acc_d;
      rem_q <= rem_d;
      neg_q <= neg_d;
      neg_rem_q <= neg_rem_d;
      b_zero_q <= b_zero_d;
      done_q <= done_d;
      dz_q <= dz_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign div_by_zero = dz_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: random and directed checks of mult_div_unit against a cycle-level arithmetic model
module tb_mult_div_unit;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0] op = 2'd0;
  logic [31:0] a = 32'd0, b = 32'd0, wdata = 32'd0;
  logic busy, done, div_by_zero;
  logic [31:0] hi, lo;
  int n_cmp = 0, n_err = 0;
  logic m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
  int m_left = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [63:0] p_res = 64'd0;
  mult_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Full result {hi, lo} from plain 64-bit arithmetic
  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    if (o[1] && y == 32'd0) return {x, 32'hFFFF_FFFF};
    case (o)
      2'd0: return sx * sy;
      2'd1: return ux * uy;
      2'd2: begin
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction
  // Model: an accepted start delivers its result 33 edges later; writes land only while idle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dz <= 1'b0;
      m_left <= 0;
      m_hi <= 32'd0;
      m_lo <= 32'd0;
    end else begin
      m_done <= 1'b0;
      m_dz <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_dz <= p_dz;
          {m_hi, m_lo} <= p_res;
        end
        m_left <= m_left - 1;
      end else begin
        if (hi_we) m_hi <= wdata;
        if (lo_we) m_lo <= wdata;
        if (start) begin
          m_busy <= 1'b1;
          m_left <= 33;
          p_res <= ref_res(op, a, b);
          p_dz <= op[1] && b == 32'd0;
        end
      end
    end
  end
  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
    if (m_done) chk("div_by_zero", 64'(div_by_zero), 64'(m_dz));
  end
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz,
                        input bit disturb, input string name);
    int n;
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    while (!done && n < 40) begin
      if (disturb && n == 5) begin
        start = 1'b1;
        op = 2'($urandom_range(0, 3));
        a = $urandom;
        b = $urandom;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = $urandom;
      end else begin
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    chk({name, "_latency"}, 64'(n), 64'd33);
    chk({name, "_hi"}, 64'(hi), 64'(eh));
    chk({name, "_lo"}, 64'(lo), 64'(el));
    chk({name, "_dz"}, 64'(div_by_zero), 64'(edz));
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    run_op(2'd0, 32'd12, 32'hFFFF_FFDE, 32'hFFFF_FFFF, 32'hFFFF_FE68, 1'b0, 1'b0, "mult");
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, "multu");
    run_op(2'd3, 32'd4321, 32'd1234, 32'd619, 32'd3, 1'b0, 1'b0, "divu");
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, "div_neg");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0, "div_ovf");
    run_op(2'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0, "div_zero");
    hi_we = 1'b1;
    wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b1;
    wdata = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    chk("mthi", 64'(hi), 64'h1234_5678);
    chk("mtlo", 64'(lo), 64'h9ABC_DEF0);
    run_op(2'd0, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, 1'b1, "busy_window");
    run_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, "back_to_back");
    op = 2'd2;
    a = 32'd1000;
    b = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_done", 64'(done), 64'd0);
    chk("midreset_hi", 64'(hi), 64'd0);
    chk("midreset_lo", 64'(lo), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op(2'd1, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 32'h0000_0000, 1'b0, 1'b0, "after_reset");
    repeat (2500) begin
      start = $urandom_range(0, 3) == 0;
      op = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      hi_we = $urandom_range(0, 7) == 0;
      lo_we = $urandom_range(0, 7) == 0;
      wdata = $urandom;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_idle", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
